// File: rtl/sonar_echo_emulator.sv
// Sonar echo emulator: trigger width qualify, burst delay, echo pulse, holdoff.
// Optional length jitter from an 8-bit LFSR when SONAR_EMU_JITTER_EN is defined.
module sonar_echo_emulator #(
  parameter int unsigned TRIG_MIN    = 500,
  parameter int unsigned BURST_CYC   = 10000,
  parameter int unsigned HOLDOFF_CYC = 50000,
  parameter logic [19:0] ECHO_MAX    = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Trigger,
  input  logic [19:0] echo_len,
  output logic        Echo,
  output logic        busy,
  output logic [1:0]  Flags
);

  localparam int unsigned M0 =
    (BURST_CYC > HOLDOFF_CYC) ? BURST_CYC : HOLDOFF_CYC;
  localparam int unsigned EM = 32'(ECHO_MAX);
  localparam int unsigned M1 = (M0 > EM) ? M0 : EM;
  localparam int CW = $clog2(M1 + 1);
  localparam logic [15:0] TMIN = 16'(TRIG_MIN);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF
  } state_t;

  state_t state, state_n;
  logic sync1, trig_s, trig_prev;
  logic [15:0] width_cnt, width_n;
  logic [CW-1:0] cnt, cnt_n, n_last;
  logic [20:0] len_q, len_n, len_in;
  logic [19:0] n_w;
  logic over;
  logic clamp_q, clamp_n;
  logic short_q, short_n;
  logic echo_n;
  logic accept;

`ifdef SONAR_EMU_JITTER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign len_in = {1'b0, echo_len} + {17'd0, lfsr[3:0]};
`else
  assign len_in = {1'b0, echo_len};
`endif

  // Pulse width: zero length still gives a one-cycle echo
  always_comb begin
    over = len_q > {1'b0, ECHO_MAX};
    if (len_q == 21'd0) begin
      n_w = 20'd1;
    end else if (over) begin
      n_w = ECHO_MAX;
    end else begin
      n_w = len_q[19:0];
    end
    n_last = CW'(n_w) - CW'(1);
  end

  always_comb begin
    state_n = state;
    width_n = width_cnt;
    cnt_n   = cnt;
    len_n   = len_q;
    clamp_n = clamp_q;
    short_n = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig_s && !trig_prev) begin
          state_n = TRIG_HIGH;
          width_n = 16'd1;
        end
      end
      TRIG_HIGH: begin
        if (trig_s) begin
          if (width_cnt < TMIN) width_n = width_cnt + 16'd1;
        end else if (width_cnt >= TMIN) begin
          accept  = 1'b1;
          len_n   = len_in;
          clamp_n = 1'b0;
          cnt_n   = '0;
          state_n = BURST;
        end else begin
          short_n = 1'b1;
          state_n = IDLE;
        end
      end
      BURST: begin
        if (cnt == BURST_LAST) begin
          state_n = ECHO;
          cnt_n   = '0;
          clamp_n = clamp_q | over;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ECHO: begin
        if (cnt == n_last) begin
          state_n = HOLDOFF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    echo_n = (state_n == ECHO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      trig_s    <= 1'b0;
      trig_prev <= 1'b0;
      width_cnt <= '0;
      cnt       <= '0;
      len_q     <= '0;
      clamp_q   <= 1'b0;
      short_q   <= 1'b0;
      Echo      <= 1'b0;
    end else begin
      state     <= state_n;
      sync1     <= Trigger;
      trig_s    <= sync1;
      trig_prev <= trig_s;
      width_cnt <= width_n;
      cnt       <= cnt_n;
      len_q     <= len_n;
      clamp_q   <= clamp_n;
      short_q   <= short_n;
      Echo      <= echo_n;
    end
  end

  assign busy  = (state != IDLE);
  assign Flags = {short_q, clamp_q};

endmodule

// File: tb/tb_sonar_echo_emulator.sv
// Directed bench for sonar_echo_emulator: long-delay instance A and
// short-delay clamped instance B share clock and reset.
module tb_sonar_echo_emulator;

  logic clk = 1'b0;
  logic rst;
  logic trig_a, trig_b;
  logic [19:0] len_a, len_b;
  logic echo_a, echo_b, busy_a, busy_b;
  logic [1:0] flags_a, flags_b;

  int n_chk = 0;
  int n_err = 0;
  int d, w, n, hits, eh;
  logic [1:0] fl3;
  logic [7:0] lfsr_a = 8'hA5;
  logic [7:0] lfsr_b = 8'hA5;

  always #5 clk = ~clk;

  sonar_echo_emulator #(
    .TRIG_MIN(500), .BURST_CYC(10000),
    .HOLDOFF_CYC(2000), .ECHO_MAX(20'hFFFFF)
  ) dut_a (
    .clk(clk), .reset(rst), .Trigger(trig_a),
    .echo_len(len_a), .Echo(echo_a),
    .busy(busy_a), .Flags(flags_a)
  );

  sonar_echo_emulator #(
    .TRIG_MIN(500), .BURST_CYC(100),
    .HOLDOFF_CYC(1000), .ECHO_MAX(20'd1000)
  ) dut_b (
    .clk(clk), .reset(rst), .Trigger(trig_b),
    .echo_len(len_b), .Echo(echo_b),
    .busy(busy_b), .Flags(flags_b)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic echo_of(input bit sel);
    return sel ? echo_b : echo_a;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic [1:0] flags_of(input bit sel);
    return sel ? flags_b : flags_a;
  endfunction

  task automatic set_trig(input bit sel, input logic v);
    if (sel) trig_b = v;
    else trig_a = v;
  endtask

  // Expected width for an accepted trigger; steps the jitter model
  task automatic expw(input bit sel, input int len,
                      input int emax, output int nw);
    int l;
    logic [7:0] s;
    l = len;
    s = sel ? lfsr_b : lfsr_a;
`ifdef SONAR_EMU_JITTER_EN
    l = l + int'(s[3:0]);
    s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
`endif
    if (sel) lfsr_b = s;
    else lfsr_a = s;
    nw = (l == 0) ? 1 : ((l > emax) ? emax : l);
  endtask

  task automatic pulse(input bit sel, input int cyc);
    @(posedge clk);
    #1 set_trig(sel, 1'b1);
    repeat (cyc) @(posedge clk);
    #1 set_trig(sel, 1'b0);
  endtask

  task automatic wait_idle(input bit sel);
    for (int i = 0; i < 60000; i++) begin
      if (!busy_of(sel)) break;
      @(posedge clk);
      #1;
    end
    check("idle", busy_of(sel), 0);
  endtask

  task automatic run(input bit sel, input int cyc,
                     output int dly, output int wid);
    wait_idle(sel);
    pulse(sel, cyc);
    dly = -1;
    wid = 0;
    for (int k = 1; k <= 12000; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) fl3 = flags_of(sel);
      if (echo_of(sel)) begin
        dly = k - 1;
        break;
      end
    end
    if (dly >= 0) begin
      wid = 1;
      for (int k = 0; k < 40000; k++) begin
        @(posedge clk);
        #1;
        if (!echo_of(sel)) break;
        wid++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    trig_a = 1'b0;
    trig_b = 1'b0;
    len_a = '0;
    len_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_echo_a", echo_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_flags_a", flags_a, 0);
    check("rst_echo_b", echo_b, 0);
    check("rst_flags_b", flags_b, 0);
    rst = 1'b0;

    len_a = 20'd29000;
    expw(0, 29000, 1048575, n);
    run(0, 500, d, w);
    len_a = 20'd7;
    check("valid_dly", d, 10002);
    check("valid_wid", w, n);
    check("valid_flags", flags_a, 0);
    check("valid_holdoff", busy_a, 1);

    pulse(1, 499);
    hits = 0;
    eh = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      hits += int'(flags_b[1]);
      eh |= int'(echo_b);
    end
    check("short_pulse", hits, 1);
    check("short_echo", eh, 0);
    check("short_busy", busy_b, 0);

    len_b = 20'd5000;
    expw(1, 5000, 1000, n);
    run(1, 500, d, w);
    check("clamp_dly", d, 102);
    check("clamp_wid", w, n);
    check("clamp_flag", flags_b, 1);
    wait_idle(1);
    check("clamp_sticky", flags_b, 1);

    len_b = 20'd300;
    expw(1, 300, 1000, n);
    run(1, 500, d, w);
    len_b = 20'd9;
    check("clamp_clear", fl3, 0);
    check("n300_wid", w, n);

    pulse(1, 600);
    eh = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      #1;
      eh |= int'(echo_b);
    end
    check("holdoff_echo", eh, 0);
    check("holdoff_busy", busy_b, 0);
    len_b = 20'd300;
    expw(1, 300, 1000, n);
    run(1, 600, d, w);
    check("after_ho_dly", d, 102);
    check("after_ho_wid", w, n);

    wait_idle(1);
    len_b = 20'd500;
    expw(1, 500, 1000, n);
    pulse(1, 500);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (echo_b) break;
    end
    check("pre_rst_echo", echo_b, 1);
    repeat (99) @(posedge clk);
    #1;
    check("mid_echo", echo_b, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_echo", echo_b, 0);
    check("mrst_busy", busy_b, 0);
    check("mrst_flags", flags_b, 0);
    rst = 1'b0;
    lfsr_a = 8'hA5;
    lfsr_b = 8'hA5;
    len_b = 20'd200;
    expw(1, 200, 1000, n);
    run(1, 500, d, w);
    check("post_rst_dly", d, 102);
    check("post_rst_wid", w, n);

    len_b = 20'd0;
    expw(1, 0, 1000, n);
    run(1, 500, d, w);
    check("zero_dly", d, 102);
    check("zero_wid", w, n);

`ifdef SONAR_EMU_JITTER_EN
    len_a = 20'd1000;
    expw(0, 1000, 1048575, n);
    run(0, 500, d, w);
    check("jit_wid", w, n);
    check("jit_range", int'(w >= 1000 && w <= 1015), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
